train_job_sequencer: RTL

- Upstream stage of the FP/BP/WG training-phase FSM.
- Accepts training-job commands over a valid/ready handshake: iteration count plus stride mode.
- Issues one start pulse per iteration to the phase FSM and holds its stride input stable.
- Tracks the FSM's fixed 3x11-cycle phase schedule with a mirror counter, so status and done signals are available to the host side without any feedback from the FSM.

---
 rtl/train_pkg.sv | 33 +++
 rtl/train_job_sequencer_if.sv | 32 +++
 rtl/phase_mirror_cnt.sv | 45 ++++
 rtl/train_job_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
`default_nettype none
// ============================================================================
// train_pkg : shared phase encodings, defaults and sequencer state type
// Rev 1.0
// ============================================================================
package train_pkg;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_FP   = 2'b01;
    localparam logic [1:0] PH_BP   = 2'b10;
    localparam logic [1:0] PH_WG   = 2'b11;

    localparam int PHASE_CYCLES_DEFAULT = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    // Phase the FSM occupies at a given mirror-count position
    function automatic logic [1:0] phase_of(input logic [5:0] cnt, input int pc);
        if (int'(cnt) < pc)
            return PH_FP;
        else if (int'(cnt) < 2 * pc)
            return PH_BP;
        return PH_WG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/train_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// train_job_sequencer_if : host command handshake, FSM drive and status
// Rev 1.0
// ============================================================================
interface train_job_sequencer_if #(
    parameter int ITER_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ITER_W-1:0] cmd_iters;
    logic              cmd_stride;
    logic              abort;
    logic              fsm_start;
    logic              fsm_stride;
    logic              busy;
    logic [1:0]        phase;
    logic [ITER_W-1:0] iter_idx;
    logic              done;
    logic              done_aborted;

    modport master (
        output cmd_valid, cmd_iters, cmd_stride, abort,
        input  cmd_ready, fsm_start, fsm_stride, busy, phase, iter_idx, done, done_aborted
    );

    modport slave (
        input  cmd_valid, cmd_iters, cmd_stride, abort,
        output cmd_ready, fsm_start, fsm_stride, busy, phase, iter_idx, done, done_aborted
    );
endinterface
`default_nettype wire

// File: rtl/phase_mirror_cnt.sv
`default_nettype none
// ============================================================================
// phase_mirror_cnt : 0..3*PHASE_CYCLES-1 counter shadowing the phase FSM
// Rev 1.0
// ============================================================================
module phase_mirror_cnt
    import train_pkg::*;
#(
    parameter int PHASE_CYCLES = PHASE_CYCLES_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       fsm_rst_n,
    input  wire logic       load,
    input  wire logic       run,
    output logic [1:0]      phase,
    output logic            tc
);
    localparam logic [5:0] C_LAST = 6'(3 * PHASE_CYCLES - 1);

    logic [5:0] r_cnt;
    logic [1:0] r_phase;

    assign tc    = (r_cnt == C_LAST);
    assign phase = r_phase;

    // Phase is registered alongside the count so it lines up with the FSM state
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            r_cnt   <= '0;
            r_phase <= PH_IDLE;
        end else if (load) begin
            r_cnt   <= '0;
            r_phase <= PH_FP;
        end else if (run) begin
            if (r_cnt == C_LAST) begin
                r_cnt   <= '0;
                r_phase <= PH_IDLE;
            end else begin
                r_cnt   <= r_cnt + 6'd1;
                r_phase <= phase_of(r_cnt + 6'd1, PHASE_CYCLES);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/train_job_sequencer.sv
`default_nettype none
// ============================================================================
// train_job_sequencer : issues per-iteration starts to the FP/BP/WG FSM
// Rev 1.0
// ============================================================================
module train_job_sequencer
    import train_pkg::*;
#(
    parameter int ITER_W       = 8,
    parameter int PHASE_CYCLES = PHASE_CYCLES_DEFAULT,
    parameter int GAP_CYCLES   = 2
) (
    input  wire logic             clk,
    input  wire logic             fsm_rst_n,
    train_job_sequencer_if.slave  bus
);
    localparam logic [ITER_W-1:0] C_ONE      = ITER_W'(1);
    localparam logic [3:0]        C_GAP_LAST = 4'(GAP_CYCLES - 1);

    seq_state_t        r_state;
    logic [ITER_W-1:0] r_iters;
    logic [ITER_W-1:0] r_iter_idx;
    logic [3:0]        r_gap_cnt;
    logic              r_abort_pending;
    logic              r_fsm_start;
    logic              r_fsm_stride;
    logic              r_busy;
    logic              r_done;
    logic              r_done_aborted;
    logic              w_abort;
    logic              w_tc;
    logic [1:0]        w_phase;

    // An abort seen in the decision cycle itself counts as pending
    assign w_abort = r_abort_pending | bus.abort;

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.fsm_start    = r_fsm_start;
    assign bus.fsm_stride   = r_fsm_stride;
    assign bus.busy         = r_busy;
    assign bus.phase        = w_phase;
    assign bus.iter_idx     = r_iter_idx;
    assign bus.done         = r_done;
    assign bus.done_aborted = r_done_aborted;

    phase_mirror_cnt #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_mirror (
        .clk       (clk),
        .fsm_rst_n (fsm_rst_n),
        .load      (r_state == S_START),
        .run       (r_state == S_RUN),
        .phase     (w_phase),
        .tc        (w_tc)
    );

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            r_state         <= S_IDLE;
            r_iters         <= '0;
            r_iter_idx      <= '0;
            r_gap_cnt       <= '0;
            r_abort_pending <= 1'b0;
            r_fsm_start     <= 1'b0;
            r_fsm_stride    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_done_aborted  <= 1'b0;
        end else begin
            r_fsm_start    <= 1'b0;
            r_done         <= 1'b0;
            r_done_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_iters         <= bus.cmd_iters;
                        r_fsm_stride    <= bus.cmd_stride;
                        r_iter_idx      <= '0;
                        r_abort_pending <= 1'b0;
                        if (bus.cmd_iters != '0) begin
                            r_state     <= S_START;
                            r_fsm_start <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_abort_pending <= w_abort;
                    r_state         <= S_RUN;
                end
                S_RUN: begin
                    r_abort_pending <= w_abort;
                    if (w_tc) begin
                        if (w_abort || (r_iter_idx == r_iters - C_ONE)) begin
                            r_state        <= S_DONE;
                            r_done         <= 1'b1;
                            r_done_aborted <= w_abort;
                            r_busy         <= 1'b0;
                        end else begin
                            r_iter_idx <= r_iter_idx + C_ONE;
                            r_gap_cnt  <= '0;
                            if (GAP_CYCLES > 0) begin
                                r_state <= S_GAP;
                            end else begin
                                r_state     <= S_START;
                                r_fsm_start <= 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    r_abort_pending <= w_abort;
                    if (r_gap_cnt == C_GAP_LAST) begin
                        if (w_abort) begin
                            r_state        <= S_DONE;
                            r_done         <= 1'b1;
                            r_done_aborted <= 1'b1;
                            r_busy         <= 1'b0;
                        end else begin
                            r_state     <= S_START;
                            r_fsm_start <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_abort_pending <= 1'b0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
